// File: rtl/traffic_light_four_lane.sv
// Two-phase four-way intersection light controller driven by fixed cycle-count dwell timers.
// Define PEDESTRIAN_REQ_EN to add pedestrian request flags that end green early.
module traffic_light_four_lane #(
    parameter int unsigned GREEN_TIME  = 50,
    parameter int unsigned YELLOW_TIME = 10,
    parameter int unsigned ALLRED_TIME = 5,
    parameter int unsigned MIN_GREEN   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic pedestrian_ew,
    input  logic pedestrian_ns,
    output logic ew_green,
    output logic ew_yellow,
    output logic ew_red,
    output logic ns_green,
    output logic ns_yellow,
    output logic ns_red
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cut_ns;
    logic             cut_ew;

`ifdef PEDESTRIAN_REQ_EN
    logic req_ns;
    logic req_ew;
    logic req_ns_nxt;
    logic req_ew_nxt;

    // A latched request may only end green once the minimum green has elapsed.
    assign cut_ns = req_ns && (cnt >= MIN_LAST);
    assign cut_ew = req_ew && (cnt >= MIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ns <= 1'b0;
            req_ew <= 1'b0;
        end else begin
            req_ns <= req_ns_nxt;
            req_ew <= req_ew_nxt;
        end
    end

    // Requests latch only while their approach is green; entering yellow clears them.
    always_comb begin
        req_ns_nxt = req_ns;
        req_ew_nxt = req_ew;
        if (state == NS_GREEN && pedestrian_ns) req_ns_nxt = 1'b1;
        if (state == EW_GREEN && pedestrian_ew) req_ew_nxt = 1'b1;
        if (state_nxt == NS_YELLOW && state != NS_YELLOW) req_ns_nxt = 1'b0;
        if (state_nxt == EW_YELLOW && state != EW_YELLOW) req_ew_nxt = 1'b0;
    end
`else
    logic unused_ped;

    assign unused_ped = pedestrian_ns ^ pedestrian_ew;
    assign cut_ns     = 1'b0;
    assign cut_ew     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NS_GREEN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Fixed phase ring; the dwell counter restarts on every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            NS_GREEN:  if (cnt == GREEN_LAST || cut_ns) state_nxt = NS_YELLOW;
            NS_YELLOW: if (cnt == YELLOW_LAST)          state_nxt = ALLRED_A;
            ALLRED_A:  if (cnt == ALLRED_LAST)          state_nxt = EW_GREEN;
            EW_GREEN:  if (cnt == GREEN_LAST || cut_ew) state_nxt = EW_YELLOW;
            EW_YELLOW: if (cnt == YELLOW_LAST)          state_nxt = ALLRED_B;
            ALLRED_B:  if (cnt == ALLRED_LAST)          state_nxt = NS_GREEN;
            default:                                    state_nxt = NS_GREEN;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // Moore lamp decode; unused codes show red both ways until recovery.
    always_comb begin
        ns_green  = 1'b0;
        ns_yellow = 1'b0;
        ns_red    = 1'b0;
        ew_green  = 1'b0;
        ew_yellow = 1'b0;
        ew_red    = 1'b0;
        case (state)
            NS_GREEN:  begin ns_green  = 1'b1; ew_red = 1'b1; end
            NS_YELLOW: begin ns_yellow = 1'b1; ew_red = 1'b1; end
            EW_GREEN:  begin ew_green  = 1'b1; ns_red = 1'b1; end
            EW_YELLOW: begin ew_yellow = 1'b1; ns_red = 1'b1; end
            default:   begin ns_red    = 1'b1; ew_red = 1'b1; end
        endcase
    end
endmodule

// File: tb/tb_traffic_light_four_lane.sv
// Self-checking bench for traffic_light_four_lane: directed table, corner sequences and
// randomized pedestrian/reset stimulus against a phase/elapsed-time reference model.
module tb_traffic_light_four_lane;
    localparam int G_T = 50;
    localparam int Y_T = 10;
    localparam int A_T = 5;
    localparam int MIN_G = 10;
`ifdef PEDESTRIAN_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ped_ew = 1'b0;
    logic ped_ns = 1'b0;
    logic ew_green, ew_yellow, ew_red, ns_green, ns_yellow, ns_red;

    traffic_light_four_lane #(
        .GREEN_TIME (G_T),
        .YELLOW_TIME(Y_T),
        .ALLRED_TIME(A_T),
        .MIN_GREEN  (MIN_G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pedestrian_ew(ped_ew),
        .pedestrian_ns(ped_ns),
        .ew_green     (ew_green),
        .ew_yellow    (ew_yellow),
        .ew_red       (ew_red),
        .ns_green     (ns_green),
        .ns_yellow    (ns_yellow),
        .ns_red       (ns_red)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int safety_viol = 0;

    // Reference model: phase index, cycles spent in phase, pending requests.
    int m_p = 0;
    int m_e = 0;
    bit m_rn = 1'b0;
    bit m_re = 1'b0;
    int dur[6] = '{G_T, Y_T, A_T, G_T, Y_T, A_T};

    typedef struct {
        int         wait_cycles;
        logic [2:0] exp_state;
        logic [5:0] exp_lamps;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [5:0] lamp_of(input int p);
        return {p == 0, p == 1, p >= 2, p == 3, p == 4, !(p == 3 || p == 4)};
    endfunction

    function automatic logic [5:0] lamps();
        return {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit pn, input bit pe);
        bit adv;
        if (r) begin
            m_p = 0; m_e = 0; m_rn = 1'b0; m_re = 1'b0;
            return;
        end
        adv = (m_e == dur[m_p] - 1) ||
              (PED_EN && ((m_p == 0 && m_rn) || (m_p == 3 && m_re)) && m_e >= MIN_G - 1);
        if (PED_EN && m_p == 0 && pn) m_rn = 1'b1;
        if (PED_EN && m_p == 3 && pe) m_re = 1'b1;
        if (adv) begin
            if (m_p == 0) m_rn = 1'b0;
            if (m_p == 3) m_re = 1'b0;
            m_p = (m_p + 1) % 6;
            m_e = 0;
        end else begin
            m_e++;
        end
    endtask

    // One clock: model sees the inputs present at the edge, outputs sampled 1ns later.
    task automatic step();
        bit r, pn, pe;
        logic [8:0] exp_v;
        r = rst; pn = ped_ns; pe = ped_ew;
        @(posedge clk);
        model_edge(r, pn, pe);
        #1;
        exp_v = {m_p[2:0], lamp_of(m_p)};
        check("cycle", {23'd0, dut.state, lamps()}, {23'd0, exp_v});
        if (!$onehot({ns_green, ns_yellow, ns_red}) || !$onehot({ew_green, ew_yellow, ew_red}) ||
            (ns_green && ew_green) || (!ns_red && !ew_red))
            safety_viol++;
    endtask

    task automatic wait_model(input int p, input int e);
        int n = 0;
        while (!(m_p == p && m_e == e) && n < 400) begin
            step();
            n++;
        end
        check("wait_bound", {31'd0, (m_p == p && m_e == e)}, 32'd1);
    endtask

    task automatic measure_len(input int s, output int len);
        len = 1;
        step();
        while (dut.state == s && len < 400) begin
            len++;
            step();
        end
    endtask

    initial begin
        int len, n, prev, cyc;
        int entries[$];
        int seq_bad;

        vecs[0] = '{0,   3'd0, 6'b100_001};
        vecs[1] = '{G_T, 3'd1, 6'b010_001};
        vecs[2] = '{Y_T, 3'd2, 6'b001_001};
        vecs[3] = '{A_T, 3'd3, 6'b001_100};
        vecs[4] = '{G_T, 3'd4, 6'b001_010};
        vecs[5] = '{Y_T, 3'd5, 6'b001_001};
        vecs[6] = '{A_T, 3'd0, 6'b100_001};

        // Reset held for two edges, then the full nominal ring against constants.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
`ifdef PEDESTRIAN_REQ_EN
        check("reset_req", {30'd0, dut.req_ns, dut.req_ew}, 32'd0);
`endif
        for (int i = 0; i < 7; i++) begin
            repeat (vecs[i].wait_cycles) step();
            check($sformatf("vec%0d_state", i), {29'd0, dut.state}, {29'd0, vecs[i].exp_state});
            check($sformatf("vec%0d_lamps", i), {26'd0, lamps()}, {26'd0, vecs[i].exp_lamps});
        end

        // Free run: ordered ring with a 130-cycle period.
        seq_bad = 0;
        prev = int'(dut.state);
        for (int i = 1; i <= 400; i++) begin
            step();
            if (int'(dut.state) != prev) begin
                if (int'(dut.state) != (prev + 1) % 6) seq_bad++;
                if (dut.state == 0) entries.push_back(i);
                prev = int'(dut.state);
            end
        end
        check("ring_order", seq_bad, 0);
        check("ring_entries", {31'd0, entries.size() >= 2}, 32'd1);
        if (entries.size() >= 2)
            check("ring_period", entries[entries.size()-1] - entries[entries.size()-2],
                  2 * (G_T + Y_T + A_T));

        // Two-cycle EW pulse at EW_GREEN cnt=20.
        wait_model(3, 20);
        ped_ew = 1'b1;
        step();
        check("ew_pulse_hold", {29'd0, dut.state}, 32'd3);
        step();
        ped_ew = 1'b0;
        check("ew_pulse_yellow", {29'd0, dut.state}, PED_EN ? 32'd4 : 32'd3);
`ifdef PEDESTRIAN_REQ_EN
        check("ew_req_cleared", {31'd0, dut.req_ew}, 32'd0);
        measure_len(4, len);
        check("ew_yellow_len", len, Y_T);
        check("ew_allred_b", {29'd0, dut.state}, 32'd5);
`endif

        // NS pulse at NS_GREEN cnt=3: green ends after minimum green.
        wait_model(0, 3);
        ped_ns = 1'b1;
        step();
        ped_ns = 1'b0;
        n = 0;
        while (dut.state == 0 && n < 100) begin
            step();
            n++;
        end
        check("ns_min_green", 4 + n, PED_EN ? MIN_G : G_T);

        // Requests while not green on their approach are ignored.
        wait_model(3, 5);
        ped_ns = 1'b1;
        step();
        ped_ns = 1'b0;
        wait_model(2, 0);
        ped_ns = 1'b1;
        ped_ew = 1'b1;
        step();
        ped_ns = 1'b0;
        ped_ew = 1'b0;
        wait_model(3, 0);
        measure_len(3, len);
        check("ew_green_full", len, G_T);
        wait_model(0, 0);
        measure_len(0, len);
        check("ns_green_full", len, G_T);

        // Reset during EW_YELLOW with inputs high.
        wait_model(4, 3);
        ped_ew = 1'b1;
        ped_ns = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ped_ew = 1'b0;
        ped_ns = 1'b0;
        check("rst_yellow_state", {29'd0, dut.state}, 32'd0);
        check("rst_yellow_lamps", {26'd0, lamps()}, 32'b100_001);
        measure_len(0, len);
        check("rst_ns_green_len", len, G_T);

        // Reset while an EW request is latched.
        wait_model(3, 20);
        ped_ew = 1'b1;
        step();
        ped_ew = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_req_state", {29'd0, dut.state}, 32'd0);
`ifdef PEDESTRIAN_REQ_EN
        check("rst_req_flags", {30'd0, dut.req_ns, dut.req_ew}, 32'd0);
`endif
        measure_len(0, len);
        check("rst_req_green_len", len, G_T);

        // Randomized pedestrian traffic with rare resets.
        for (int i = 0; i < 3000; i++) begin
            ped_ns = ($urandom_range(0, 11) == 0);
            ped_ew = ($urandom_range(0, 11) == 0);
            rst    = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        ped_ns = 1'b0;
        ped_ew = 1'b0;

        check("lamp_safety", safety_viol, 0);
        cyc = n_tests;
        $display("[TB] %0d tests run, %0d failed", cyc, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
